// File: rtl/debug_trace.sv
// debug_trace: commit-trace ring buffer with halt latch and hang watchdog.
//
// Watches NCH retire channels per cycle (channel 0 is the oldest). It
// records the most recent DEPTH commits and counts retired instructions.
// It latches a halt request, and it flags a hang after TIMEOUT
// consecutive commit-free cycles.
//
// Ports:
//   clock            sole clock, rising edge
//   reset            asynchronous, active-low
//   debug_valid      per-channel commit valid             [NCH]
//   debug_halt       per-channel halt request             [NCH]
//   debug_pc         per-channel PC                       [NCH*32]
//   debug_regWen     per-channel register write enable    [NCH]
//   debug_regWaddr   per-channel destination register     [NCH*5]
//   debug_regWdata   per-channel write data               [NCH*32]
//   clear            synchronous soft clear back to RUN
//   trace_rd_idx     readback index, 0 = newest entry
//   trace_rd_*       registered readback of the addressed entry
//   trace_fill       valid entries in the ring, saturates at DEPTH
//   commit_count     recorded commits, saturates at all-ones
//   halted / hung    state levels
//   halt_pulse / hang_pulse  one-cycle pulses on state entry
module debug_trace #(
  parameter int NCH     = 2,
  parameter int DEPTH   = 16,
  parameter int TIMEOUT = 1024,
  parameter int CNTW    = 32
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic [NCH-1:0]           debug_valid,
  input  logic [NCH-1:0]           debug_halt,
  input  logic [NCH*32-1:0]        debug_pc,
  input  logic [NCH-1:0]           debug_regWen,
  input  logic [NCH*5-1:0]         debug_regWaddr,
  input  logic [NCH*32-1:0]        debug_regWdata,
  input  logic                     clear,
  input  logic [$clog2(DEPTH)-1:0] trace_rd_idx,
  output logic                     trace_rd_valid,
  output logic [31:0]              trace_rd_pc,
  output logic                     trace_rd_wen,
  output logic [4:0]               trace_rd_waddr,
  output logic [31:0]              trace_rd_wdata,
  output logic [$clog2(DEPTH):0]   trace_fill,
  output logic [CNTW-1:0]          commit_count,
  output logic                     halted,
  output logic                     hung,
  output logic                     halt_pulse,
  output logic                     hang_pulse
);

  localparam int AW = $clog2(DEPTH);
  localparam int FW = AW + 1;
  localparam int CW = $clog2(NCH + 1);
  localparam int IW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_HALTED = 2'd1,
    ST_HUNG   = 2'd2
  } state_t;

  state_t          state_r;
  logic [IW-1:0]   idle_cnt_r;
  logic [AW-1:0]   wr_ptr_r;

  logic [31:0]     mem_pc_r    [DEPTH];
  logic            mem_wen_r   [DEPTH];
  logic [4:0]      mem_waddr_r [DEPTH];
  logic [31:0]     mem_wdata_r [DEPTH];

  logic [NCH-1:0]  accept_s;
  logic            halt_hit_s;
  logic [CW-1:0]   n_acc_s;
  logic [AW-1:0]   slot_s [NCH];
  logic [NCH-1:0]  ch_wen_s;

  logic [AW-1:0]   wr_ptr_nxt_s;
  logic [FW+1:0]   fill_sum_s;
  logic [FW-1:0]   fill_nxt_s;
  logic [CNTW:0]   cnt_sum_s;
  logic [CNTW-1:0] cnt_nxt_s;

  logic [AW-1:0]   rd_addr_s;
  logic            rd_valid_s;
  logic [31:0]     rd_pc_s;
  logic            rd_wen_s;
  logic [4:0]      rd_waddr_s;
  logic [31:0]     rd_wdata_s;

  // Acceptance mask: channels up to and including the first halting one.
  always_comb begin
    accept_s   = {NCH{1'b0}};
    halt_hit_s = 1'b0;
    if (state_r == ST_RUN && !clear) begin
      for (int k = 0; k < NCH; k++) begin
        if (!halt_hit_s) begin
          accept_s[k] = debug_valid[k];
          if (debug_valid[k] && debug_halt[k]) begin
            halt_hit_s = 1'b1;
          end else begin
            halt_hit_s = 1'b0;
          end
        end else begin
          accept_s[k] = 1'b0;
        end
      end
    end else begin
      accept_s   = {NCH{1'b0}};
      halt_hit_s = 1'b0;
    end
  end

  // Compacted slot per accepted channel and the number accepted.
  always_comb begin
    n_acc_s = {CW{1'b0}};
    for (int k = 0; k < NCH; k++) begin
      slot_s[k]   = wr_ptr_r + AW'(n_acc_s);
      ch_wen_s[k] = debug_regWen[k] && (debug_regWaddr[5*k +: 5] != 5'd0);
      if (accept_s[k]) begin
        n_acc_s = n_acc_s + CW'(1);
      end else begin
        n_acc_s = n_acc_s;
      end
    end
  end

  // Next pointer, fill and commit count (clear wins; saturation on overflow).
  always_comb begin
    fill_sum_s = {2'b00, trace_fill} + (FW+2)'(n_acc_s);
    cnt_sum_s  = {1'b0, commit_count} + (CNTW+1)'(n_acc_s);
    if (clear) begin
      wr_ptr_nxt_s = {AW{1'b0}};
      fill_nxt_s   = {FW{1'b0}};
      cnt_nxt_s    = {CNTW{1'b0}};
    end else begin
      wr_ptr_nxt_s = wr_ptr_r + AW'(n_acc_s);
      if (fill_sum_s > (FW+2)'(DEPTH)) begin
        fill_nxt_s = FW'(DEPTH);
      end else begin
        fill_nxt_s = fill_sum_s[FW-1:0];
      end
      if (cnt_sum_s[CNTW]) begin
        cnt_nxt_s = {CNTW{1'b1}};
      end else begin
        cnt_nxt_s = cnt_sum_s[CNTW-1:0];
      end
    end
  end

  // Write-first readback: address against the post-edge pointer and
  // forward any entry being written this same cycle.
  always_comb begin
    rd_addr_s  = wr_ptr_nxt_s - AW'(1) - trace_rd_idx;
    rd_valid_s = ({1'b0, trace_rd_idx} < fill_nxt_s);
    rd_pc_s    = mem_pc_r[rd_addr_s];
    rd_wen_s   = mem_wen_r[rd_addr_s];
    rd_waddr_s = mem_waddr_r[rd_addr_s];
    rd_wdata_s = mem_wdata_r[rd_addr_s];
    for (int k = 0; k < NCH; k++) begin
      if (accept_s[k] && slot_s[k] == rd_addr_s) begin
        rd_pc_s    = debug_pc[32*k +: 32];
        rd_wen_s   = ch_wen_s[k];
        rd_waddr_s = debug_regWaddr[5*k +: 5];
        rd_wdata_s = debug_regWdata[32*k +: 32];
      end else begin
        rd_pc_s    = rd_pc_s;
        rd_wen_s   = rd_wen_s;
        rd_waddr_s = rd_waddr_s;
        rd_wdata_s = rd_wdata_s;
      end
    end
    if (!rd_valid_s) begin
      rd_pc_s    = 32'd0;
      rd_wen_s   = 1'b0;
      rd_waddr_s = 5'd0;
      rd_wdata_s = 32'd0;
    end else begin
      rd_pc_s    = rd_pc_s;
      rd_wen_s   = rd_wen_s;
      rd_waddr_s = rd_waddr_s;
      rd_wdata_s = rd_wdata_s;
    end
  end

  // Trace RAM write port; contents are not reset.
  always_ff @(posedge clock) begin
    for (int k = 0; k < NCH; k++) begin
      if (accept_s[k]) begin
        mem_pc_r[slot_s[k]]    <= debug_pc[32*k +: 32];
        mem_wen_r[slot_s[k]]   <= ch_wen_s[k];
        mem_waddr_r[slot_s[k]] <= debug_regWaddr[5*k +: 5];
        mem_wdata_r[slot_s[k]] <= debug_regWdata[32*k +: 32];
      end
    end
  end

  // Pointer, fill, counter and registered readback.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_ptr_r       <= {AW{1'b0}};
      trace_fill     <= {FW{1'b0}};
      commit_count   <= {CNTW{1'b0}};
      trace_rd_valid <= 1'b0;
      trace_rd_pc    <= 32'd0;
      trace_rd_wen   <= 1'b0;
      trace_rd_waddr <= 5'd0;
      trace_rd_wdata <= 32'd0;
    end else begin
      wr_ptr_r       <= wr_ptr_nxt_s;
      trace_fill     <= fill_nxt_s;
      commit_count   <= cnt_nxt_s;
      trace_rd_valid <= rd_valid_s;
      trace_rd_pc    <= rd_pc_s;
      trace_rd_wen   <= rd_wen_s;
      trace_rd_waddr <= rd_waddr_s;
      trace_rd_wdata <= rd_wdata_s;
    end
  end

  // RUN/HALTED/HUNG state machine with watchdog and registered flags.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_r    <= ST_RUN;
      idle_cnt_r <= {IW{1'b0}};
      halted     <= 1'b0;
      hung       <= 1'b0;
      halt_pulse <= 1'b0;
      hang_pulse <= 1'b0;
    end else if (clear) begin
      state_r    <= ST_RUN;
      idle_cnt_r <= {IW{1'b0}};
      halted     <= 1'b0;
      hung       <= 1'b0;
      halt_pulse <= 1'b0;
      hang_pulse <= 1'b0;
    end else begin
      halt_pulse <= 1'b0;
      hang_pulse <= 1'b0;
      case (state_r)
        ST_RUN: begin
          if (|debug_valid) begin
            idle_cnt_r <= {IW{1'b0}};
          end else begin
            idle_cnt_r <= idle_cnt_r + IW'(1);
          end
          if (halt_hit_s) begin
            state_r    <= ST_HALTED;
            halted     <= 1'b1;
            halt_pulse <= 1'b1;
          end else if (!(|debug_valid) && idle_cnt_r == IW'(TIMEOUT - 1)) begin
            state_r    <= ST_HUNG;
            hung       <= 1'b1;
            hang_pulse <= 1'b1;
          end
        end
        ST_HALTED: state_r <= ST_HALTED;
        ST_HUNG:   state_r <= ST_HUNG;
        default: begin
          state_r <= ST_RUN;
          halted  <= 1'b0;
          hung    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_debug_trace.sv
// Directed self-checking bench for debug_trace (NCH=2, DEPTH=16, TIMEOUT=8).
module tb_debug_trace;

  localparam int NCH     = 2;
  localparam int DEPTH   = 16;
  localparam int TIMEOUT = 8;
  localparam int CNTW    = 32;

  logic              clock;
  logic              reset;
  logic [NCH-1:0]    debug_valid;
  logic [NCH-1:0]    debug_halt;
  logic [NCH*32-1:0] debug_pc;
  logic [NCH-1:0]    debug_regWen;
  logic [NCH*5-1:0]  debug_regWaddr;
  logic [NCH*32-1:0] debug_regWdata;
  logic              clear;
  logic [3:0]        trace_rd_idx;
  logic              trace_rd_valid;
  logic [31:0]       trace_rd_pc;
  logic              trace_rd_wen;
  logic [4:0]        trace_rd_waddr;
  logic [31:0]       trace_rd_wdata;
  logic [4:0]        trace_fill;
  logic [CNTW-1:0]   commit_count;
  logic              halted;
  logic              hung;
  logic              halt_pulse;
  logic              hang_pulse;

  int err_cnt = 0;
  int chk_cnt = 0;

  debug_trace #(.NCH(NCH), .DEPTH(DEPTH), .TIMEOUT(TIMEOUT), .CNTW(CNTW)) dut (
    .clock          (clock),
    .reset          (reset),
    .debug_valid    (debug_valid),
    .debug_halt     (debug_halt),
    .debug_pc       (debug_pc),
    .debug_regWen   (debug_regWen),
    .debug_regWaddr (debug_regWaddr),
    .debug_regWdata (debug_regWdata),
    .clear          (clear),
    .trace_rd_idx   (trace_rd_idx),
    .trace_rd_valid (trace_rd_valid),
    .trace_rd_pc    (trace_rd_pc),
    .trace_rd_wen   (trace_rd_wen),
    .trace_rd_waddr (trace_rd_waddr),
    .trace_rd_wdata (trace_rd_wdata),
    .trace_fill     (trace_fill),
    .commit_count   (commit_count),
    .halted         (halted),
    .hung           (hung),
    .halt_pulse     (halt_pulse),
    .hang_pulse     (hang_pulse)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    chk_cnt++;
    if (obs !== exp) begin
      err_cnt++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic idle_in();
    debug_valid = 2'b00;
    debug_halt  = 2'b00;
  endtask

  task automatic set_ch(input int k, input logic v, input logic h, input logic [31:0] pc,
                        input logic wen, input logic [4:0] wa, input logic [31:0] wd);
    debug_valid[k]          = v;
    debug_halt[k]           = h;
    debug_pc[32*k +: 32]    = pc;
    debug_regWen[k]         = wen;
    debug_regWaddr[5*k +: 5] = wa;
    debug_regWdata[32*k +: 32] = wd;
  endtask

  task automatic do_clear();
    idle_in();
    clear = 1'b1;
    tick();
    clear = 1'b0;
  endtask

  initial begin
    reset = 1'b0;
    clear = 1'b0;
    trace_rd_idx = 4'd0;
    debug_valid = '0; debug_halt = '0; debug_pc = '0;
    debug_regWen = '0; debug_regWaddr = '0; debug_regWdata = '0;
    #2;
    check_val("rst_fill",  64'(trace_fill), 64'd0);
    check_val("rst_count", 64'(commit_count), 64'd0);
    check_val("rst_flags", 64'({halted, hung, halt_pulse, hang_pulse, trace_rd_valid}), 64'd0);
    tick();
    tick();
    reset = 1'b1;

    // 20 single commits on channel 0; ring wraps.
    for (int i = 0; i < 20; i++) begin
      set_ch(0, 1'b1, 1'b0, 32'h8000_0000 + 32'(4 * i), 1'b1, 5'(i % 31 + 1), 32'(i));
      set_ch(1, 1'b0, 1'b0, 32'd0, 1'b0, 5'd0, 32'd0);
      tick();
    end
    idle_in();
    check_val("single_fill",  64'(trace_fill), 64'd16);
    check_val("single_count", 64'(commit_count), 64'd20);
    trace_rd_idx = 4'd0;
    tick();
    check_val("single_idx0_pc",    64'(trace_rd_pc), 64'h8000_004C);
    check_val("single_idx0_wdata", 64'(trace_rd_wdata), 64'd19);
    check_val("single_idx0_valid", 64'(trace_rd_valid), 64'd1);
    trace_rd_idx = 4'd15;
    tick();
    check_val("single_idx15_pc", 64'(trace_rd_pc), 64'h8000_0010);

    // Dual commit with halt on channel 0: channel 1 dropped.
    do_clear();
    set_ch(0, 1'b1, 1'b1, 32'h100, 1'b1, 5'd1, 32'h11);
    set_ch(1, 1'b1, 1'b0, 32'h104, 1'b1, 5'd2, 32'h22);
    tick();
    check_val("halt_pulse_on", 64'(halt_pulse), 64'd1);
    check_val("halt_level",    64'(halted), 64'd1);
    check_val("halt_count",    64'(commit_count), 64'd1);
    check_val("halt_fill",     64'(trace_fill), 64'd1);
    set_ch(0, 1'b1, 1'b0, 32'h108, 1'b1, 5'd3, 32'h33);
    set_ch(1, 1'b1, 1'b0, 32'h10C, 1'b1, 5'd4, 32'h44);
    trace_rd_idx = 4'd0;
    tick();
    idle_in();
    check_val("halt_pulse_off", 64'(halt_pulse), 64'd0);
    check_val("halt_stays",     64'(halted), 64'd1);
    check_val("halt_frozen",    64'(commit_count), 64'd1);
    check_val("halt_rd_pc",     64'(trace_rd_pc), 64'h100);
    trace_rd_idx = 4'd1;
    tick();
    check_val("halt_rd1_valid", 64'(trace_rd_valid), 64'd0);

    // Compaction and x0 filtering, then readback bounds.
    do_clear();
    set_ch(0, 1'b0, 1'b0, 32'h1FC, 1'b1, 5'd7, 32'h77);
    set_ch(1, 1'b1, 1'b0, 32'h200, 1'b1, 5'd0, 32'hAA);
    tick();
    check_val("x0_fill", 64'(trace_fill), 64'd1);
    set_ch(0, 1'b1, 1'b0, 32'h204, 1'b1, 5'd2, 32'hB0);
    set_ch(1, 1'b1, 1'b0, 32'h208, 1'b1, 5'd3, 32'hB1);
    trace_rd_idx = 4'd2;
    tick();
    idle_in();
    check_val("pair_fill",    64'(trace_fill), 64'd3);
    check_val("oldest_valid", 64'(trace_rd_valid), 64'd1);
    check_val("oldest_pc",    64'(trace_rd_pc), 64'h200);
    check_val("x0_wen",       64'(trace_rd_wen), 64'd0);
    trace_rd_idx = 4'd1;
    tick();
    check_val("ch0_pc",    64'(trace_rd_pc), 64'h204);
    check_val("ch0_waddr", 64'(trace_rd_waddr), 64'd2);
    trace_rd_idx = 4'd0;
    tick();
    check_val("ch1_pc",    64'(trace_rd_pc), 64'h208);
    check_val("ch1_wen",   64'(trace_rd_wen), 64'd1);
    check_val("ch1_wdata", 64'(trace_rd_wdata), 64'hB1);
    trace_rd_idx = 4'd5;
    tick();
    check_val("oob_valid", 64'(trace_rd_valid), 64'd0);
    check_val("oob_data",  64'({trace_rd_pc, trace_rd_wen, trace_rd_waddr}), 64'd0);
    check_val("oob_wdata", 64'(trace_rd_wdata), 64'd0);

    // Hang detection: 7 idle, commit, 8 idle.
    do_clear();
    for (int i = 0; i < 7; i++) tick();
    check_val("hang_early", 64'(hung), 64'd0);
    set_ch(0, 1'b1, 1'b0, 32'h300, 1'b0, 5'd0, 32'd0);
    set_ch(1, 1'b0, 1'b0, 32'd0, 1'b0, 5'd0, 32'd0);
    tick();
    idle_in();
    for (int i = 0; i < 7; i++) tick();
    check_val("hang_at7", 64'(hung), 64'd0);
    tick();
    check_val("hang_level", 64'(hung), 64'd1);
    check_val("hang_pulse_on", 64'(hang_pulse), 64'd1);
    tick();
    check_val("hang_pulse_off", 64'(hang_pulse), 64'd0);
    check_val("hang_stays", 64'(hung), 64'd1);

    // Clear beats a commit in HALTED.
    do_clear();
    check_val("clear_from_hung", 64'(hung), 64'd0);
    set_ch(0, 1'b1, 1'b1, 32'h400, 1'b1, 5'd5, 32'h5);
    set_ch(1, 1'b0, 1'b0, 32'd0, 1'b0, 5'd0, 32'd0);
    tick();
    check_val("halt2", 64'(halted), 64'd1);
    set_ch(0, 1'b1, 1'b0, 32'h300, 1'b1, 5'd6, 32'h6);
    clear = 1'b1;
    trace_rd_idx = 4'd0;
    tick();
    clear = 1'b0;
    idle_in();
    check_val("clr_halted", 64'(halted), 64'd0);
    check_val("clr_fill",   64'(trace_fill), 64'd0);
    check_val("clr_count",  64'(commit_count), 64'd0);
    check_val("clr_rd_valid", 64'(trace_rd_valid), 64'd0);

    // Asynchronous reset mid-burst.
    set_ch(0, 1'b1, 1'b0, 32'h500, 1'b1, 5'd1, 32'h1);
    set_ch(1, 1'b1, 1'b0, 32'h504, 1'b1, 5'd2, 32'h2);
    tick(); tick(); tick();
    check_val("burst_count", 64'(commit_count), 64'd6);
    #3;
    reset = 1'b0;
    #1;
    check_val("arst_count", 64'(commit_count), 64'd0);
    check_val("arst_fill",  64'(trace_fill), 64'd0);
    check_val("arst_rd",    64'({trace_rd_valid, trace_rd_pc}), 64'd0);
    check_val("arst_flags", 64'({halted, hung, halt_pulse, hang_pulse}), 64'd0);
    idle_in();
    tick();
    reset = 1'b1;
    tick();

    $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
    $finish;
  end

endmodule
